// File: rtl/eq_pkg.sv
// eq_pkg: shared constants and FSM state encoding for the equalizer output capture block
package eq_pkg;
    localparam int DATA_BIT_NUM = 16;
    localparam int DEPTH = 1024;
    localparam int ADDR_W = $clog2(DEPTH);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPTURE = 2'd1,
        PREFETCH = 2'd2,
        READOUT = 2'd3
    } state_t;
endpackage

// File: rtl/eq_output_capture_if.sv
// eq_output_capture_if: valid/ready replay port of the capture buffer
// master: rd_data, rd_valid, rd_last out; rd_ready in. slave: the consumer view.
interface eq_output_capture_if #(
    parameter int DATA_BIT_NUM = eq_pkg::DATA_BIT_NUM
);
    logic [DATA_BIT_NUM-1:0] rd_data;
    logic rd_valid;
    logic rd_ready;
    logic rd_last;
    modport master(output rd_data, output rd_valid, output rd_last, input rd_ready);
    modport slave(input rd_data, input rd_valid, input rd_last, output rd_ready);
endinterface

// File: rtl/eq_sample_ram.sv
// eq_sample_ram: simple dual-port sample RAM, sync write, 1-cycle sync read
// clk/rst: clock and sync reset (output register only); we/waddr/wdata: write port;
// re/raddr: read request; q: registered read data, holds while re is low.
module eq_sample_ram #(
    parameter int DATA_BIT_NUM = eq_pkg::DATA_BIT_NUM,
    parameter int DEPTH = eq_pkg::DEPTH,
    parameter int ADDR_W = eq_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_BIT_NUM-1:0] wdata,
    input  logic                    re,
    input  logic [ADDR_W-1:0]       raddr,
    output logic [DATA_BIT_NUM-1:0] q
);
    logic [DATA_BIT_NUM-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (re) q <= mem[raddr];
    end
endmodule

// File: rtl/eq_output_capture.sv
// eq_output_capture: arms, captures N filter samples into RAM, then replays them over rd
// clk/rst: clock, sync active-high reset; sample_in/sample_valid: input stream;
// arm/abort: control pulses; capture_len: record length (0 = DEPTH);
// busy/capturing/done/overrun: status; rd: replay port (master side).
module eq_output_capture
    import eq_pkg::*;
#(
    parameter int DATA_BIT_NUM = eq_pkg::DATA_BIT_NUM,
    parameter int DEPTH = eq_pkg::DEPTH,
    parameter int ADDR_W = eq_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_BIT_NUM-1:0] sample_in,
    input  logic                    sample_valid,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [ADDR_W-1:0]       capture_len,
    output logic                    busy,
    output logic                    capturing,
    output logic                    done,
    output logic                    overrun,
    eq_output_capture_if.master     rd
);
    state_t state;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, len_m1;
    logic [ADDR_W:0] len_q;
    logic xfer, we, re;
    assign len_m1 = ADDR_W'(len_q - 1'b1);
    assign xfer = rd.rd_valid && rd.rd_ready;
    assign we = state == CAPTURE && sample_valid && !abort;
    // RAM output register is the rd_data register: it only advances on a prefetch or an
    // accepted non-final sample, so it holds under back-pressure and refills with no bubble.
    assign re = !abort && (state == PREFETCH || (state == READOUT && xfer && !rd.rd_last));
    assign busy = state != IDLE;
    assign capturing = state == CAPTURE;
    eq_sample_ram #(
        .DATA_BIT_NUM(DATA_BIT_NUM),
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk(clk),
        .rst(rst),
        .we(we),
        .waddr(wr_ptr),
        .wdata(sample_in),
        .re(re),
        .raddr(rd_ptr),
        .q(rd.rd_data)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            len_q <= '0;
            rd.rd_valid <= 1'b0;
            rd.rd_last <= 1'b0;
            done <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                rd.rd_valid <= 1'b0;
                rd.rd_last <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (arm) begin
                        len_q <= capture_len == '0 ? (ADDR_W+1)'(DEPTH) : {1'b0, capture_len};
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        overrun <= 1'b0;
                        state <= CAPTURE;
                    end
                    CAPTURE: if (sample_valid) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == len_m1) state <= PREFETCH;
                    end
                    PREFETCH: begin
                        if (sample_valid) overrun <= 1'b1;
                        rd_ptr <= rd_ptr + 1'b1;
                        rd.rd_valid <= 1'b1;
                        rd.rd_last <= len_m1 == '0;
                        state <= READOUT;
                    end
                    READOUT: begin
                        if (sample_valid) overrun <= 1'b1;
                        if (xfer) begin
                            if (rd.rd_last) begin
                                rd.rd_valid <= 1'b0;
                                rd.rd_last <= 1'b0;
                                done <= 1'b1;
                                state <= IDLE;
                            end else begin
                                // rd_ptr is the index now being fetched, i.e. the next one presented
                                rd_ptr <= rd_ptr + 1'b1;
                                rd.rd_last <= rd_ptr == len_m1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_eq_output_capture.sv
// tb_eq_output_capture: randomized self-checking bench, replay compared with a queue model
module tb_eq_output_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] sample_in = '0;
    logic sample_valid = 1'b0;
    logic arm = 1'b0;
    logic abort = 1'b0;
    logic [9:0] capture_len = '0;
    logic busy, capturing, done, overrun;
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int n_last, last_pos, n_done, hold_bad, first_valid;
    bit timeout;
    int pat[6] = '{1, 0, 0, 1, 0, 1};

    eq_output_capture_if #(.DATA_BIT_NUM(16)) rd();

    eq_output_capture dut (
        .clk(clk),
        .rst(rst),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .arm(arm),
        .abort(abort),
        .capture_len(capture_len),
        .busy(busy),
        .capturing(capturing),
        .done(done),
        .overrun(overrun),
        .rd(rd)
    );

    always #5 clk = ~clk;

    task automatic arm_cap(input int len, input bit junk);
        @(negedge clk);
        arm = 1'b1;
        capture_len = 10'(len);
        sample_valid = junk;
        sample_in = 16'hDEAD;
        @(negedge clk);
        arm = 1'b0;
        sample_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic push(input logic [15:0] v, input int gap);
        sample_in = v;
        sample_valid = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Drains the replay port; mode 0 ready high, 1 fixed toggle pattern, 2 random.
    task automatic collect(input int mode, input int max_cyc, input bit hold_sv, input int arm_at);
        bit stalled;
        logic [15:0] prev;
        int after, k;
        bit ready;
        stalled = 0;
        prev = '0;
        after = -1;
        k = 0;
        got_q.delete();
        n_last = 0;
        last_pos = -1;
        n_done = 0;
        hold_bad = 0;
        first_valid = -1;
        timeout = 1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (done) n_done++;
            if (after >= 0 && c >= after) begin
                timeout = 0;
                break;
            end
            if (stalled && (!rd.rd_valid || rd.rd_data !== prev)) hold_bad++;
            if (rd.rd_valid && first_valid < 0) first_valid = c;
            ready = mode == 0 ? 1'b1 : mode == 1 ? pat[k % 6] != 0 : 1'($urandom_range(0, 1));
            if (rd.rd_valid) k++;
            rd.rd_ready = ready;
            sample_valid = hold_sv;
            sample_in = 16'($urandom);
            arm = c == arm_at;
            if (rd.rd_valid && ready) begin
                got_q.push_back(rd.rd_data);
                if (rd.rd_last) begin
                    n_last++;
                    last_pos = got_q.size() - 1;
                    after = c + 3;
                end
                stalled = 0;
            end else begin
                stalled = rd.rd_valid;
                prev = rd.rd_data;
            end
        end
        rd.rd_ready = 1'b0;
        sample_valid = 1'b0;
        arm = 1'b0;
    endtask

    task automatic test_reset;
        rd.rd_ready = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, capturing, done, overrun, rd.rd_valid, rd.rd_last} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000", {busy, capturing, done, overrun, rd.rd_valid, rd.rd_last});
        end
        checks++;
        if (rd.rd_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_rd_data got %h want 0000", rd.rd_data);
        end
    endtask

    task automatic test_basic;
        arm_cap(8, 1'b1);
        checks++;
        if (capturing !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_capturing got %b%b want 11", capturing, busy);
        end
        for (int i = 1; i <= 8; i++) push(16'(i), 0);
        collect(0, 40, 1'b0, -1);
        checks++;
        if (timeout || first_valid !== 0) begin
            errors++;
            $display("FAIL basic_latency got %0d timeout %0d want 0", first_valid, timeout);
        end
        checks++;
        if (got_q.size() !== 8) begin
            errors++;
            $display("FAIL basic_count got %0d want 8", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (n_last !== 1 || last_pos !== 7 || n_done !== 1) begin
            errors++;
            $display("FAIL basic_last_done got last %0d@%0d done %0d want 1@7 1", n_last, last_pos, n_done);
        end
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL basic_end got busy %b overrun %b want 0 0", busy, overrun);
        end
    endtask

    task automatic test_gapped;
        logic [15:0] v[4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
        arm_cap(4, 1'b0);
        for (int i = 0; i < 4; i++) push(v[i], i == 3 ? 0 : 3);
        collect(0, 40, 1'b0, -1);
        checks++;
        if (timeout || got_q.size() !== 4 || first_valid !== 0) begin
            errors++;
            $display("FAIL gapped_count got %0d first %0d want 4 0", got_q.size(), first_valid);
        end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++;
            if (got_q[i] !== v[i]) begin
                errors++;
                $display("FAIL gapped_data[%0d] got %h want %h", i, got_q[i], v[i]);
            end
        end
    endtask

    task automatic test_back_pressure;
        arm_cap(6, 1'b0);
        for (int i = 0; i < 6; i++) push(16'($urandom), 0);
        collect(1, 60, 1'b0, -1);
        checks++;
        if (timeout || got_q.size() !== 6 || hold_bad !== 0) begin
            errors++;
            $display("FAIL bp_count got %0d hold_bad %0d want 6 0", got_q.size(), hold_bad);
        end
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (n_last !== 1 || last_pos !== 5 || n_done !== 1) begin
            errors++;
            $display("FAIL bp_last got last %0d@%0d done %0d want 1@5 1", n_last, last_pos, n_done);
        end
    endtask

    task automatic test_full_depth;
        int bad;
        bad = 0;
        arm_cap(0, 1'b0);
        for (int i = 0; i < 1024; i++) push(16'(i), 0);
        checks++;
        if (dut.wr_ptr !== 10'd0) begin
            errors++;
            $display("FAIL full_wrap got %0d want 0", dut.wr_ptr);
        end
        collect(0, 1100, 1'b0, -1);
        for (int i = 0; i < got_q.size() && i < 1024; i++) if (got_q[i] !== 16'(i)) bad++;
        checks++;
        if (timeout || got_q.size() !== 1024 || bad !== 0) begin
            errors++;
            $display("FAIL full_data got %0d samples %0d wrong want 1024 0", got_q.size(), bad);
        end
        checks++;
        if (n_last !== 1 || last_pos !== 1023 || n_done !== 1) begin
            errors++;
            $display("FAIL full_last got last %0d@%0d done %0d want 1@1023 1", n_last, last_pos, n_done);
        end
    endtask

    task automatic test_overrun;
        arm_cap(5, 1'b0);
        for (int i = 0; i < 5; i++) push(16'($urandom), 0);
        collect(1, 60, 1'b1, 2);
        checks++;
        if (timeout || got_q.size() !== 5 || n_done !== 1) begin
            errors++;
            $display("FAIL ovr_count got %0d done %0d want 5 1", got_q.size(), n_done);
        end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovr_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovr_sticky got overrun %b busy %b want 1 0", overrun, busy);
        end
        arm_cap(3, 1'b0);
        checks++;
        if (overrun !== 1'b0 || capturing !== 1'b1) begin
            errors++;
            $display("FAIL ovr_clear got overrun %b capturing %b want 0 1", overrun, capturing);
        end
        for (int i = 0; i < 3; i++) push(16'($urandom), 1);
        collect(0, 40, 1'b0, -1);
        checks++;
        if (got_q !== exp_q) begin
            errors++;
            $display("FAIL ovr_rearm got %0d samples want %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_abort_reset;
        int bad;
        arm_cap(8, 1'b0);
        for (int i = 0; i < 3; i++) push(16'($urandom), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy, capturing, rd.rd_valid} !== 3'b0) begin
            errors++;
            $display("FAIL abort_cap got %b want 000", {busy, capturing, rd.rd_valid});
        end
        arm = 1'b1;
        abort = 1'b1;
        capture_len = 10'd5;
        @(negedge clk);
        arm = 1'b0;
        abort = 1'b0;
        checks++;
        if ({busy, capturing, rd.rd_valid} !== 3'b0) begin
            errors++;
            $display("FAIL arm_abort got %b want 000", {busy, capturing, rd.rd_valid});
        end
        bad = 0;
        rd.rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || rd.rd_valid) bad++;
        end
        rd.rd_ready = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_quiet got %0d events want 0", bad);
        end
        arm_cap(6, 1'b0);
        for (int i = 0; i < 6; i++) push(16'($urandom), 0);
        rd.rd_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd.rd_ready = 1'b0;
        checks++;
        if ({busy, capturing, rd.rd_valid, rd.rd_last, done} !== 5'b0 || rd.rd_data !== 16'h0) begin
            errors++;
            $display("FAIL rst_readout got %b data %h want 00000 0000", {busy, capturing, rd.rd_valid, rd.rd_last, done}, rd.rd_data);
        end
        arm_cap(7, 1'b0);
        for (int i = 0; i < 7; i++) push(16'($urandom), $urandom_range(0, 1));
        collect(2, 100, 1'b0, -1);
        checks++;
        if (timeout || got_q !== exp_q || n_done !== 1 || hold_bad !== 0) begin
            errors++;
            $display("FAIL abort_fresh got %0d samples done %0d want %0d 1", got_q.size(), n_done, exp_q.size());
        end
    endtask

    task automatic test_random;
        int len;
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(1, 40);
            arm_cap(len, 1'($urandom_range(0, 1)));
            for (int i = 0; i < len; i++) push(16'($urandom), i == len - 1 ? 0 : $urandom_range(0, 2));
            collect(2, 400, 1'b0, -1);
            checks++;
            if (timeout || got_q !== exp_q || hold_bad !== 0) begin
                errors++;
                $display("FAIL rand%0d_data got %0d samples hold_bad %0d want %0d 0", t, got_q.size(), hold_bad, len);
            end
            checks++;
            if (n_last !== 1 || last_pos !== len - 1 || n_done !== 1 || first_valid !== 0) begin
                errors++;
                $display("FAIL rand%0d_last got last %0d@%0d done %0d first %0d want 1@%0d 1 0", t, n_last, last_pos, n_done, first_valid, len - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_back_pressure();
        test_full_depth();
        test_overrun();
        test_abort_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
